// File: rtl/vdp_port_ctrl.sv
// CPU-side port controller for a TMS9918-style VDP: data/control port protocol, VRAM sequencing,
// control registers and status. Define VDP_IRQ_OUT_EN to drive a registered n_int output.

module vdp_port_ctrl #(
    parameter int ADDR_W   = 14,
    parameter int NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_wr,
    input  logic              io_rd,
    input  logic              port_sel,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              busy,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_wr,
    output logic              vram_rd,
    output logic [7:0]        vram_wdata,
    input  logic [7:0]        vram_rdata,
    output logic [1:0]        mode,
    output logic [13:0]       name_table_addr,
    output logic [13:0]       font_addr,
    output logic [13:0]       color_table_addr,
    output logic [13:0]       sprite_attr_addr,
    output logic [13:0]       sprite_pattern_table_addr,
    output logic              video_on,
    output logic              sprite_large,
    output logic              sprite_enlarged,
    output logic              vert_retrace_int,
    output logic [3:0]        text_color,
    output logic [3:0]        back_color,
    input  logic              interrupt_flag,
    input  logic              sprite_collision,
    input  logic              too_many_sprites,
    input  logic [4:0]        sprite5,
    output logic              n_int
);

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAPTURE, WR_DATA} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic              flag_reg;
    logic [7:0]        latch_reg, rbuf_reg, wdata_reg, cpu_dout_reg;
    logic              f_reg, c_reg, s5_reg;
    logic [4:0]        fifth_reg;
    logic [7:0]        r_reg [NUM_REGS];
    logic [NUM_REGS-1:0] reg_we;

    logic idle, ctrl_wr, data_wr, ctrl_rd, data_rd;
    logic ctrl_second, reg_wr, addr_load, prefetch_start, mode2;
    logic [7:0] status_byte;

    // Strobes are only honoured while idle; a write strobe masks a simultaneous read.
    assign idle    = (state_reg == IDLE);
    assign ctrl_wr = idle & io_wr & port_sel;
    assign data_wr = idle & io_wr & ~port_sel;
    assign ctrl_rd = idle & io_rd & ~io_wr & port_sel;
    assign data_rd = idle & io_rd & ~io_wr & ~port_sel;

    assign ctrl_second    = ctrl_wr & flag_reg;
    assign reg_wr         = ctrl_second & cpu_din[7];
    assign addr_load      = ctrl_second & ~cpu_din[7];
    assign prefetch_start = (ctrl_second & (cpu_din[7:6] == 2'b00)) | data_rd;

    assign status_byte = {f_reg, s5_reg, c_reg, fifth_reg};

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_we
            assign reg_we[gi] = reg_wr && (cpu_din[2:0] == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_we[i]) r_reg[i] <= latch_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        vram_rd    = 1'b0;
        vram_wr    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (data_wr)             state_next = WR_DATA;
                else if (prefetch_start) state_next = RD_ISSUE;
            end
            RD_ISSUE: begin
                busy       = 1'b1;
                vram_rd    = 1'b1;
                state_next = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            WR_DATA: begin
                busy       = 1'b1;
                vram_wr    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg     <= '0;
            flag_reg     <= 1'b0;
            latch_reg    <= '0;
            rbuf_reg     <= '0;
            wdata_reg    <= '0;
            cpu_dout_reg <= '0;
        end else begin
            if (addr_load)
                addr_reg <= ADDR_W'({cpu_din[5:0], latch_reg});
            else if (state_reg == RD_CAPTURE || state_reg == WR_DATA)
                addr_reg <= addr_reg + ADDR_W'(1);

            if (ctrl_wr)                         flag_reg <= ~flag_reg;
            else if (data_wr | data_rd | ctrl_rd) flag_reg <= 1'b0;

            if (ctrl_wr & ~flag_reg) latch_reg <= cpu_din;
            if (data_wr)             wdata_reg <= cpu_din;

            if (state_reg == RD_CAPTURE)   rbuf_reg <= vram_rdata;
            else if (state_reg == WR_DATA) rbuf_reg <= wdata_reg;

            if (data_rd)      cpu_dout_reg <= rbuf_reg;
            else if (ctrl_rd) cpu_dout_reg <= status_byte;
        end
    end

    // Sticky status: a set in the same cycle as a status read survives the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_reg     <= 1'b0;
            c_reg     <= 1'b0;
            s5_reg    <= 1'b0;
            fifth_reg <= '0;
        end else begin
            f_reg  <= interrupt_flag   | (f_reg  & ~ctrl_rd);
            c_reg  <= sprite_collision | (c_reg  & ~ctrl_rd);
            s5_reg <= too_many_sprites | (s5_reg & ~ctrl_rd);
            if (!s5_reg || ctrl_rd) fifth_reg <= sprite5;
        end
    end

    assign cpu_dout   = cpu_dout_reg;
    assign vram_addr  = addr_reg;
    assign vram_wdata = wdata_reg;

    always_comb begin
        if (r_reg[1][4])      mode = 2'd0;
        else if (r_reg[0][1]) mode = 2'd2;
        else if (r_reg[1][3]) mode = 2'd3;
        else                  mode = 2'd1;
    end

    assign mode2                     = (mode == 2'd2);
    assign video_on                  = r_reg[1][6];
    assign vert_retrace_int          = r_reg[1][5];
    assign sprite_large              = r_reg[1][1];
    assign sprite_enlarged           = r_reg[1][0];
    assign name_table_addr           = {r_reg[2][3:0], 10'b0};
    assign color_table_addr          = mode2 ? {r_reg[3][7], 13'b0} : {r_reg[3], 6'b0};
    assign font_addr                 = mode2 ? {r_reg[4][2], 13'b0} : {r_reg[4][2:0], 11'b0};
    assign sprite_attr_addr          = {r_reg[5][6:0], 7'b0};
    assign sprite_pattern_table_addr = {r_reg[6][2:0], 11'b0};
    assign text_color                = r_reg[7][7:4];
    assign back_color                = r_reg[7][3:0];

    logic unused_reg_bits;
    assign unused_reg_bits = &{1'b0, r_reg[0][7:2], r_reg[0][0], r_reg[1][7], r_reg[1][2],
                               r_reg[2][7:4], r_reg[4][7:3], r_reg[5][7], r_reg[6][7:3]};

`ifdef VDP_IRQ_OUT_EN
    logic n_int_reg;
    always_ff @(posedge clk) begin
        if (reset) n_int_reg <= 1'b1;
        else       n_int_reg <= ~(f_reg & r_reg[1][5]);
    end
    assign n_int = n_int_reg;
`else
    assign n_int = 1'b1;
`endif

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Bench for vdp_port_ctrl: directed scenarios plus randomized port traffic checked against
// a transaction-level model of the port protocol, VRAM contents and register decode.

module tb_vdp_port_ctrl;
    logic        clk = 1'b0;
    logic        reset, io_wr, io_rd, port_sel;
    logic [7:0]  cpu_din, cpu_dout;
    logic        busy, vram_wr, vram_rd;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata, vram_rdata;
    logic [1:0]  mode;
    logic [13:0] name_table_addr, font_addr, color_table_addr, sprite_attr_addr, sprite_pattern_table_addr;
    logic        video_on, sprite_large, sprite_enlarged, vert_retrace_int;
    logic [3:0]  text_color, back_color;
    logic        interrupt_flag, sprite_collision, too_many_sprites;
    logic [4:0]  sprite5;
    logic        n_int;

    int n_checks = 0;
    int n_pass   = 0;

    vdp_port_ctrl dut (
        .clk(clk), .reset(reset), .io_wr(io_wr), .io_rd(io_rd), .port_sel(port_sel),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .busy(busy), .vram_addr(vram_addr),
        .vram_wr(vram_wr), .vram_rd(vram_rd), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
        .mode(mode), .name_table_addr(name_table_addr), .font_addr(font_addr),
        .color_table_addr(color_table_addr), .sprite_attr_addr(sprite_attr_addr),
        .sprite_pattern_table_addr(sprite_pattern_table_addr), .video_on(video_on),
        .sprite_large(sprite_large), .sprite_enlarged(sprite_enlarged),
        .vert_retrace_int(vert_retrace_int), .text_color(text_color), .back_color(back_color),
        .interrupt_flag(interrupt_flag), .sprite_collision(sprite_collision),
        .too_many_sprites(too_many_sprites), .sprite5(sprite5), .n_int(n_int)
    );

    always #5 clk = ~clk;

    // VRAM attached to the DUT: registered read, one-cycle latency.
    logic [7:0] vram [0:16383];
    always @(posedge clk) begin
        if (vram_wr) vram[vram_addr] <= vram_wdata;
        if (vram_rd) vram_rdata <= vram[vram_addr];
    end

    // Reference model state.
    logic [7:0] ref_mem [0:16383];
    logic [7:0] m_regs [8];
    int         m_addr;
    logic       m_flag, m_F, m_C, m_S;
    logic [7:0] m_latch, m_rbuf, m_dout;
    logic [4:0] m_fifth;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_addr = 0; m_flag = 0; m_latch = 0; m_rbuf = 0; m_dout = 0;
        m_F = 0; m_C = 0; m_S = 0; m_fifth = 0;
    endtask

    task automatic model_prefetch();
        m_rbuf = ref_mem[m_addr];
        m_addr = (m_addr + 1) % 16384;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 8) begin
            step();
            n++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s busy_timeout got=%b want=0", tag, busy);
        else n_pass++;
    endtask

    task automatic op_ctrl_wr(input logic [7:0] b);
        io_wr = 1; port_sel = 1; cpu_din = b;
        step();
        io_wr = 0;
        if (!m_flag) begin
            m_latch = b;
            m_flag  = 1;
        end else begin
            m_flag = 0;
            if (b[7]) m_regs[b[2:0]] = m_latch;
            else begin
                m_addr = {b[5:0], m_latch};
                if (!b[6]) begin
                    model_prefetch();
                    wait_idle("ctrl_wr");
                end
            end
        end
        $display("ctrl_wr  %02h  addr=%04h", b, m_addr);
    endtask

    task automatic op_data_wr(input logic [7:0] b);
        io_wr = 1; port_sel = 0; cpu_din = b;
        step();
        io_wr = 0;
        ref_mem[m_addr] = b;
        m_rbuf = b;
        m_addr = (m_addr + 1) % 16384;
        m_flag = 0;
        wait_idle("data_wr");
        $display("data_wr  %02h  addr=%04h", b, m_addr);
    endtask

    task automatic op_data_rd(output logic [7:0] got, output logic [7:0] exp);
        io_rd = 1; port_sel = 0;
        step();
        io_rd = 0;
        got = cpu_dout;
        exp = m_rbuf;
        m_dout = exp;
        m_flag = 0;
        model_prefetch();
        wait_idle("data_rd");
        $display("data_rd  got=%02h want=%02h addr=%04h", got, exp, m_addr);
    endtask

    task automatic op_ctrl_rd(output logic [7:0] got, output logic [7:0] exp);
        io_rd = 1; port_sel = 1;
        step();
        io_rd = 0;
        got = cpu_dout;
        exp = {m_F, m_S, m_C, (m_S ? m_fifth : sprite5)};
        m_dout = exp;
        m_F = 0; m_S = 0; m_C = 0; m_flag = 0;
        $display("ctrl_rd  got=%02h want=%02h", got, exp);
    endtask

    task automatic pulse_status(input logic f, input logic c, input logic s, input logic [4:0] sp);
        interrupt_flag = f; sprite_collision = c; too_many_sprites = s; sprite5 = sp;
        step();
        interrupt_flag = 0; sprite_collision = 0; too_many_sprites = 0;
        if (f) m_F = 1;
        if (c) m_C = 1;
        if (s && !m_S) begin
            m_S = 1;
            m_fifth = sp;
        end
        $display("status   F=%b C=%b 5S=%b sprite5=%0d", f, c, s, sp);
    endtask

    task automatic test_reset();
        logic [29:0] got_v, exp_v;
        logic [7:0] got, exp;
        reset = 1; io_wr = 0; io_rd = 0; port_sel = 0; cpu_din = 0;
        interrupt_flag = 0; sprite_collision = 0; too_many_sprites = 0; sprite5 = 0;
        repeat (3) step();
        reset = 0;
        model_reset();
        got_v = {cpu_dout, busy, vram_wr, vram_rd, n_int, mode, video_on, vram_addr, 1'b0};
        exp_v = {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 14'h0000, 1'b0};
        n_checks++;
        if (got_v !== exp_v) $display("FAIL reset_state got=%h want=%h", got_v, exp_v);
        else n_pass++;
        step();
        n_checks++;
        if ({vram_wr, vram_rd, busy} !== 3'b000)
            $display("FAIL reset_no_strobe got=%b want=000", {vram_wr, vram_rd, busy});
        else n_pass++;
        op_ctrl_rd(got, exp);
        n_checks++;
        if (got !== exp) $display("FAIL reset_status got=%02h want=%02h", got, exp);
        else n_pass++;
    endtask

    task automatic test_reg_write();
        op_ctrl_wr(8'h07);
        op_ctrl_wr(8'h87);
        n_checks++;
        if ({text_color, back_color} !== m_regs[7])
            $display("FAIL r7_colors got=%02h want=%02h", {text_color, back_color}, m_regs[7]);
        else n_pass++;
        n_checks++;
        if (vram_addr !== 14'(m_addr)) $display("FAIL r7_addr_kept got=%04h want=%04h", vram_addr, m_addr);
        else n_pass++;
        op_ctrl_wr(8'h55);
        op_ctrl_wr(8'h41);
        n_checks++;
        if (vram_addr !== 14'(m_addr)) $display("FAIL flag_after_reg got=%04h want=%04h", vram_addr, m_addr);
        else n_pass++;
    endtask

    task automatic test_data_write();
        op_ctrl_wr(8'h00);
        op_ctrl_wr(8'h40);
        op_data_wr(8'hAA);
        op_data_wr(8'hBB);
        n_checks++;
        if ({vram[0], vram[1]} !== {ref_mem[0], ref_mem[1]})
            $display("FAIL data_write got=%02h%02h want=%02h%02h", vram[0], vram[1], ref_mem[0], ref_mem[1]);
        else n_pass++;
        n_checks++;
        if (vram_addr !== 14'(m_addr)) $display("FAIL data_write_addr got=%04h want=%04h", vram_addr, m_addr);
        else n_pass++;
    endtask

    task automatic test_read_ahead();
        logic [7:0] got, exp;
        vram[14'h1234] = 8'h5A; ref_mem[14'h1234] = 8'h5A;
        vram[14'h1235] = 8'hC3; ref_mem[14'h1235] = 8'hC3;
        op_ctrl_wr(8'h34);
        op_ctrl_wr(8'h12);
        for (int i = 0; i < 2; i++) begin
            op_data_rd(got, exp);
            n_checks++;
            if (got !== exp) $display("FAIL read_ahead%0d got=%02h want=%02h", i, got, exp);
            else n_pass++;
        end
        n_checks++;
        if (vram_addr !== 14'(m_addr)) $display("FAIL read_ahead_addr got=%04h want=%04h", vram_addr, m_addr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] got, exp;
        op_ctrl_wr(8'hFF);
        op_ctrl_wr(8'h7F);
        op_data_wr(8'h11);
        n_checks++;
        if (vram[14'h3FFF] !== ref_mem[14'h3FFF])
            $display("FAIL wrap_write got=%02h want=%02h", vram[14'h3FFF], ref_mem[14'h3FFF]);
        else n_pass++;
        n_checks++;
        if (vram_addr !== 14'(m_addr)) $display("FAIL wrap_addr got=%04h want=%04h", vram_addr, m_addr);
        else n_pass++;
        op_ctrl_wr(8'hFF);
        op_ctrl_wr(8'h3F);
        op_data_rd(got, exp);
        n_checks++;
        if (got !== exp || vram_addr !== 14'(m_addr))
            $display("FAIL wrap_prefetch got=%02h/%04h want=%02h/%04h", got, vram_addr, exp, m_addr);
        else n_pass++;
    endtask

    task automatic test_status();
        logic [7:0] got, exp;
        logic exp_nint;
        op_ctrl_wr(8'h20);
        op_ctrl_wr(8'h81);
        pulse_status(1'b1, 1'b0, 1'b1, 5'd5);
        sprite5 = 5'd0;
        step();
        exp_nint = 1'b1;
`ifdef VDP_IRQ_OUT_EN
        exp_nint = !(m_F && m_regs[1][5]);
`endif
        n_checks++;
        if (n_int !== exp_nint) $display("FAIL n_int_assert got=%b want=%b", n_int, exp_nint);
        else n_pass++;
        op_ctrl_rd(got, exp);
        n_checks++;
        if (got !== exp) $display("FAIL status_first got=%02h want=%02h", got, exp);
        else n_pass++;
        step();
        n_checks++;
        if (n_int !== 1'b1) $display("FAIL n_int_release got=%b want=1", n_int);
        else n_pass++;
        op_ctrl_rd(got, exp);
        n_checks++;
        if (got !== exp) $display("FAIL status_cleared got=%02h want=%02h", got, exp);
        else n_pass++;
        pulse_status(1'b0, 1'b1, 1'b0, 5'd0);
        sprite5 = 5'd7;
        repeat (2) step();
        op_ctrl_rd(got, exp);
        n_checks++;
        if (got !== exp) $display("FAIL status_coll_track got=%02h want=%02h", got, exp);
        else n_pass++;
        sprite5 = 5'd0;
        repeat (2) step();
        // interrupt arriving in the same cycle as the status read
        io_rd = 1; port_sel = 1; interrupt_flag = 1;
        step();
        io_rd = 0; interrupt_flag = 0;
        got = cpu_dout;
        exp = {m_F, m_S, m_C, (m_S ? m_fifth : sprite5)};
        m_C = 0; m_S = 0; m_F = 1; m_flag = 0; m_dout = exp;
        $display("ctrl_rd  coincident set got=%02h want=%02h", got, exp);
        n_checks++;
        if (got !== exp) $display("FAIL status_set_wins_read got=%02h want=%02h", got, exp);
        else n_pass++;
        op_ctrl_rd(got, exp);
        n_checks++;
        if (got !== exp) $display("FAIL status_set_wins_after got=%02h want=%02h", got, exp);
        else n_pass++;
    endtask

    task automatic test_flag_clear();
        logic [7:0] got, exp;
        op_ctrl_wr(8'h12);
        op_data_rd(got, exp);
        n_checks++;
        if (got !== exp) $display("FAIL flag_clear_read got=%02h want=%02h", got, exp);
        else n_pass++;
        op_ctrl_wr(8'h01);
        op_ctrl_wr(8'h81);
        n_checks++;
        if ({sprite_enlarged, name_table_addr} !== {m_regs[1][0], 14'(m_regs[2][3:0] * 1024)})
            $display("FAIL flag_clear_reg got=%b/%04h want=%b/%04h", sprite_enlarged, name_table_addr,
                     m_regs[1][0], 14'(m_regs[2][3:0] * 1024));
        else n_pass++;
    endtask

    task automatic test_busy_and_collide();
        logic [7:0] got, exp;
        int a0;
        io_rd = 1; port_sel = 0;
        step();
        io_rd = 0;
        got = cpu_dout; exp = m_rbuf; m_dout = exp; m_flag = 0;
        model_prefetch();
        a0 = m_addr;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_during_fetch got=%b want=1", busy);
        else n_pass++;
        io_wr = 1; cpu_din = 8'hEE;
        step();
        io_wr = 0;
        wait_idle("busy_ignore");
        $display("data_rd  with ignored write got=%02h want=%02h", got, exp);
        n_checks++;
        if (got !== exp || vram_addr !== 14'(m_addr) || vram[a0] !== ref_mem[a0])
            $display("FAIL busy_ignore got=%02h/%04h/%02h want=%02h/%04h/%02h", got, vram_addr, vram[a0],
                     exp, m_addr, ref_mem[a0]);
        else n_pass++;
        a0 = m_addr;
        io_wr = 1; io_rd = 1; port_sel = 0; cpu_din = 8'h3C;
        step();
        io_wr = 0; io_rd = 0;
        ref_mem[m_addr] = 8'h3C; m_rbuf = 8'h3C; m_addr = (m_addr + 1) % 16384; m_flag = 0;
        wait_idle("collide");
        $display("data_wr  with simultaneous read 3c");
        n_checks++;
        if (vram[a0] !== ref_mem[a0] || cpu_dout !== m_dout || vram_addr !== 14'(m_addr))
            $display("FAIL wr_rd_collide got=%02h/%02h/%04h want=%02h/%02h/%04h", vram[a0], cpu_dout,
                     vram_addr, ref_mem[a0], m_dout, m_addr);
        else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        io_rd = 1; port_sel = 0;
        step();
        io_rd = 0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL abort_inflight got=%b want=1", busy);
        else n_pass++;
        reset = 1;
        step();
        reset = 0;
        model_reset();
        $display("reset    during prefetch");
        n_checks++;
        if ({busy, vram_rd, vram_wr, cpu_dout, vram_addr} !== {3'b000, 8'h00, 14'h0000})
            $display("FAIL abort_state got=%b%b%b/%02h/%04h want=000/00/0000", busy, vram_rd, vram_wr,
                     cpu_dout, vram_addr);
        else n_pass++;
        step();
        n_checks++;
        if ({vram_rd, vram_wr} !== 2'b00) $display("FAIL abort_no_strobe got=%b%b want=00", vram_rd, vram_wr);
        else n_pass++;
    endtask

    task automatic test_decode();
        logic [83:0] got_v, exp_v;
        logic [2:0] idx;
        logic b6;
        int em, ecol, efont;
        for (int i = 0; i < 40; i++) begin
            idx = 3'($urandom_range(0, 7));
            b6  = 1'($urandom);
            op_ctrl_wr(8'($urandom));
            op_ctrl_wr({1'b1, b6, 3'b000, idx});
            if (m_regs[1][4])      em = 0;
            else if (m_regs[0][1]) em = 2;
            else if (m_regs[1][3]) em = 3;
            else                   em = 1;
            ecol  = (em == 2) ? (m_regs[3][7] ? 8192 : 0) : m_regs[3] * 64;
            efont = (em == 2) ? (m_regs[4][2] ? 8192 : 0) : m_regs[4][2:0] * 2048;
            exp_v = {2'(em), m_regs[1][6], m_regs[1][5], m_regs[1][1], m_regs[1][0],
                     14'(m_regs[2][3:0] * 1024), 14'(efont), 14'(ecol), 14'(m_regs[5][6:0] * 128),
                     14'(m_regs[6][2:0] * 2048), 4'(m_regs[7] / 16), 4'(m_regs[7] % 16)};
            got_v = {mode, video_on, vert_retrace_int, sprite_large, sprite_enlarged, name_table_addr,
                     font_addr, color_table_addr, sprite_attr_addr, sprite_pattern_table_addr,
                     text_color, back_color};
            n_checks++;
            if (got_v !== exp_v) $display("FAIL decode%0d got=%h want=%h", i, got_v, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [7:0] got, exp, b;
        int op, bad;
        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 9);
            b  = 8'($urandom);
            if (op < 3) op_ctrl_wr(b);
            else if (op < 6) op_data_wr(b);
            else begin
                if (op < 9) op_data_rd(got, exp);
                else        op_ctrl_rd(got, exp);
                n_checks++;
                if (got !== exp) $display("FAIL rand_read%0d got=%02h want=%02h", i, got, exp);
                else n_pass++;
            end
            n_checks++;
            if (vram_addr !== 14'(m_addr)) $display("FAIL rand_addr%0d got=%04h want=%04h", i, vram_addr, m_addr);
            else n_pass++;
        end
        bad = 0;
        for (int a = 0; a < 16384; a++) if (vram[a] !== ref_mem[a]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL vram_image got=%0d differing bytes want=0", bad);
        else n_pass++;
    endtask

    initial begin
        for (int a = 0; a < 16384; a++) begin
            vram[a]    = 8'($urandom);
            ref_mem[a] = vram[a];
        end
        test_reset();
        test_reg_write();
        test_data_write();
        test_read_ahead();
        test_wrap();
        test_flag_clear();
        test_decode();
        test_status();
        test_busy_and_collide();
        test_random();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vdp_port_ctrl.md
Name: vdp_port_ctrl

Overview:
CPU-facing I/O controller for the TMS9918-style video block. It decodes the data-port and control-port protocol. It sequences CPU reads and writes of VRAM through a single VRAM port, using an auto-incrementing address and a read-ahead buffer. It holds the eight VDP control registers and drives the video block's configuration inputs, and it assembles the status register from the video block's status outputs.

Parameters:
ADDR_W, 14, VRAM address width.
NUM_REGS, 8, number of control registers; index bits beyond [2:0] are ignored.

Ports:
clk  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
io_wr  in  1  one-cycle CPU write strobe.
io_rd  in  1  one-cycle CPU read strobe.
port_sel  in  1  0 = data port (0x98), 1 = control port (0x99).
cpu_din  in  8  CPU write data.
cpu_dout  out  8  CPU read data; valid in the cycle after io_rd, held until the next read.
busy  out  1  high while a VRAM access is in flight; strobes while busy are ignored.
vram_addr  out  ADDR_W  VRAM address.
vram_wr  out  1  one-cycle VRAM write enable.
vram_rd  out  1  one-cycle VRAM read enable.
vram_wdata  out  8  VRAM write data.
vram_rdata  in  8  VRAM read data; valid 1 cycle after vram_rd.
mode  out  2  0 = text, 1 = graphics I, 2 = graphics II, 3 = multicolor.
name_table_addr, font_addr, color_table_addr, sprite_attr_addr, sprite_pattern_table_addr  out  14 each  table bases.
video_on, sprite_large, sprite_enlarged, vert_retrace_int  out  1 each.
text_color, back_color  out  4 each.
interrupt_flag, sprite_collision, too_many_sprites  in  1 each  status inputs from the video block.
sprite5  in  5  fifth-sprite number.
n_int  out  1  active-low interrupt (see Optional Feature).

Behaviour:
- Reset: R0..R7 = 0, addr = 0, latch flag = 0, first-byte latch = 0, read buffer = 0, status = 0, cpu_dout = 0, busy = 0, vram_wr = vram_rd = 0, n_int = 1. With all registers zero, mode = 1 and video_on = 0.
- Reset asserted mid-access aborts the access. No VRAM strobe is issued in the cycle after reset deasserts.
- Control port write, first byte (flag = 0): store the byte in the first-byte latch and set flag = 1.
- Control port write, second byte (flag = 1): clear the flag, then by bits [7:6]:
  - 10: write the latched byte to R[byte[2:0]]; addr is unchanged.
  - 01: addr = {byte[5:0], latch}; no prefetch.
  - 00: addr = {byte[5:0], latch}, then start a prefetch.
  - 11: treated as 10.
- Prefetch FSM states IDLE -> RD_ISSUE -> RD_CAPTURE -> IDLE.
  - RD_ISSUE: vram_rd = 1 with vram_addr = addr.
  - RD_CAPTURE: read buffer <= vram_rdata and addr <= addr + 1.
  - busy = 1 in RD_ISSUE and RD_CAPTURE.
- Data port read: cpu_dout <= read buffer, flag <= 0, then start a prefetch. The CPU always receives the previously fetched byte.
- Data port write: for one cycle, vram_wr = 1, vram_addr = addr, vram_wdata = cpu_din. The read buffer is loaded with cpu_din, addr <= addr + 1, flag <= 0, and busy is high for that one cycle.
- Address arithmetic is modulo 2^ADDR_W: 0x3FFF + 1 = 0x0000.
- Control port read:
  - cpu_dout <= {F, 5S, C, fifth}.
  - Then F, 5S and C are cleared, and flag <= 0.
- Status bit capture:
  - F is set on any cycle with interrupt_flag = 1. If a set coincides with a status read, the read returns the old value and F ends up 1 (set wins).
  - C is sticky-set by sprite_collision.
  - 5S is sticky-set by too_many_sprites. When 5S is first set, fifth <= sprite5. While 5S = 1, fifth holds; while 5S = 0, fifth tracks sprite5.
- Register decode:
  - mode: R1[4] (M1) -> 0; else R0[1] (M3) -> 2; else R1[3] (M2) -> 3; else 1.
  - video_on = R1[6]; vert_retrace_int = R1[5]; sprite_large = R1[1]; sprite_enlarged = R1[0].
  - name_table_addr = {R2[3:0], 10'b0}.
  - color_table_addr = mode 2 ? {R3[7], 13'b0} : {R3, 6'b0}.
  - font_addr = mode 2 ? {R4[2], 13'b0} : {R4[2:0], 11'b0}.
  - sprite_attr_addr = {R5[6:0], 7'b0}.
  - sprite_pattern_table_addr = {R6[2:0], 11'b0}.
  - text_color = R7[7:4]; back_color = R7[3:0].
- Simultaneous io_wr and io_rd: io_wr wins and io_rd is dropped.

Optional Feature:
VDP_IRQ_OUT_EN: when defined, n_int = !(F & R1[5]) and is registered, so it asserts 1 cycle after F sets and releases 1 cycle after the status read. When undefined, n_int is tied to 1 and the video block's own interrupt is used.

Test Plan:
1. Control writes 0x07, 0x87 -> R7 = 0x07, back_color = 7, text_color = 0, addr unchanged, flag = 0.
2. Control writes 0x00, 0x40, then data writes 0xAA, 0xBB -> VRAM 0x0000 = 0xAA, VRAM 0x0001 = 0xBB, addr = 0x0002.
3. Preload VRAM 0x1234 = 0x5A and 0x1235 = 0xC3; control writes 0x34, 0x12; wait until busy = 0; two data reads -> cpu_dout 0x5A then 0xC3, addr = 0x1237.
4. addr = 0x3FFF, data write 0x11 -> VRAM 0x3FFF = 0x11, addr = 0x0000.
5. Pulse interrupt_flag; raise too_many_sprites with sprite5 = 5; control read -> 0xC5; second control read -> 0x00. With VDP_IRQ_OUT_EN and R1 = 0x20, n_int goes low, then high after the first read.
6. Control write 0x12, then a data read (clears flag), then control writes 0x01, 0x81 -> R1 = 0x01 (not R2 = 0x12), sprite_enlarged = 1.
